// File: rtl/blink_monitor_pkg.sv
// Shared types and default parameter values for the blink_monitor block.
package blink_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_MEASURE = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  localparam int DEF_CNT_W       = 24;
  localparam int DEF_TOL         = 4;
  localparam int DEF_TIMEOUT_CYC = 24'hFFFFFF;
  localparam int DEF_FILT_LEN    = 4;

endpackage

// File: rtl/blink_monitor_edge.sv
// Synchronizer, optional debounce (BLINK_MONITOR_GLITCH_FILTER_EN) and rising-edge
// detector for the asynchronous blink input.
module blink_monitor_edge
  import blink_monitor_pkg::*;
#(
  parameter int FILT_LEN = DEF_FILT_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic blink_in,
  output logic rise
);

  if (FILT_LEN < 1) begin : g_bad_filt_len
    $error("FILT_LEN must be at least 1");
  end

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;
  logic level;

  // Stage 0/1: two-flop synchronizer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= blink_in;
      sync_p1 <= sync_p0;
    end
  end

`ifdef BLINK_MONITOR_GLITCH_FILTER_EN
  localparam int RUN_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [RUN_W-1:0] run;
  logic             filt_q;
  logic             settle;

  // The current sample completes the run, so the new level is visible in this
  // same cycle: latency is FILT_LEN-1 cycles beyond the unfiltered path.
  assign settle = (sync_p1 != filt_q) && (run == RUN_W'(FILT_LEN - 1));
  assign level  = settle ? sync_p1 : filt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      run    <= '0;
    end else begin
      filt_q <= level;
      if (sync_p1 == filt_q || settle) run <= '0;
      else                             run <= run + 1'b1;
    end
  end
`else
  assign level = sync_p1;
`endif

  // Stage 2: previous level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_p2 <= 1'b0;
    else        prev_p2 <= level;
  end

  assign rise = level & ~prev_p2;

endmodule

// File: rtl/blink_monitor.sv
// Measures the rise-to-rise period of a blinking input and reports lock/timeout.
// Optional input debounce is enabled with `define BLINK_MONITOR_GLITCH_FILTER_EN.
module blink_monitor
  import blink_monitor_pkg::*;
#(
  parameter int               CNT_W       = DEF_CNT_W,
  parameter int               TOL         = DEF_TOL,
  parameter logic [CNT_W-1:0] TIMEOUT_CYC = CNT_W'(DEF_TIMEOUT_CYC),
  parameter int               FILT_LEN    = DEF_FILT_LEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             blink_in,
  output logic [CNT_W-1:0] period_o,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout,
  output logic [15:0]      edge_cnt
);

  function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= TIMEOUT_CYC) ? TIMEOUT_CYC : (v + 1'b1);
  endfunction

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] ref_period;
  logic             rise;
  logic             match;

  blink_monitor_edge #(
    .FILT_LEN (FILT_LEN)
  ) u_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .blink_in (blink_in),
    .rise     (rise)
  );

  assign match = abs_diff(cnt, ref_period) <= CNT_W'(TOL);

  // Stage 3: period counter, FSM and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      ref_period   <= '0;
      period_o     <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
      edge_cnt     <= '0;
    end else begin
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      if (rise) begin
        cnt      <= CNT_W'(1);
        edge_cnt <= edge_cnt + 16'd1;
        if (state == ST_IDLE) begin
          state  <= ST_ARMED;
          locked <= 1'b0;
        end else begin
          period_o     <= cnt;
          period_valid <= 1'b1;
          ref_period   <= cnt;
          // ARMED has no previous period to compare against yet.
          if (state != ST_ARMED && match) begin
            state  <= ST_LOCKED;
            locked <= 1'b1;
          end else begin
            state  <= ST_MEASURE;
            locked <= 1'b0;
          end
        end
      end else if (state != ST_IDLE) begin
        if (cnt == TIMEOUT_CYC) begin
          state   <= ST_IDLE;
          cnt     <= '0;
          timeout <= 1'b1;
          locked  <= 1'b0;
        end else begin
          cnt <= sat_inc(cnt);
        end
      end
    end
  end

endmodule

// File: tb/tb_blink_monitor.sv
// Self-checking bench for blink_monitor: directed scenarios plus randomized
// waveforms compared every cycle against an event-level reference model.
module tb_blink_monitor;

  localparam int CNT_W    = 24;
  localparam int TOL      = 4;
  localparam int TO_CYC   = 200;
  localparam int FILT_LEN = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             blink_in = 1'b0;
  logic [CNT_W-1:0] period_o;
  logic             period_valid;
  logic             locked;
  logic             timeout;
  logic [15:0]      edge_cnt;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  blink_monitor #(
    .CNT_W       (CNT_W),
    .TOL         (TOL),
    .TIMEOUT_CYC (TO_CYC),
    .FILT_LEN    (FILT_LEN)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .blink_in     (blink_in),
    .period_o     (period_o),
    .period_valid (period_valid),
    .locked       (locked),
    .timeout      (timeout),
    .edge_cnt     (edge_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: tracks the filtered input level, rise times and the
  // history of measured periods; lock is "two consecutive periods within TOL".
  int  m_k;
  bit  m_active;
  int  m_last_rise;
  int  m_nper;
  int  m_lastp;
  bit  m_lh [0:3];
`ifdef BLINK_MONITOR_GLITCH_FILTER_EN
  bit  m_win [FILT_LEN];
`endif
  bit  e_pv, e_lock, e_to;
  int  e_po;
  int  e_edge;
  int  to_seen = 0;

  task automatic model_reset();
    m_k = 0; m_active = 0; m_last_rise = 0; m_nper = 0; m_lastp = 0;
    for (int i = 0; i < 4; i++) m_lh[i] = 0;
`ifdef BLINK_MONITOR_GLITCH_FILTER_EN
    for (int i = 0; i < FILT_LEN; i++) m_win[i] = 0;
`endif
    e_pv = 0; e_lock = 0; e_to = 0; e_po = 0; e_edge = 0;
  endtask

  task automatic model_step(input bit b);
    bit lnew;
    int p, d;
    m_k++;
`ifdef BLINK_MONITOR_GLITCH_FILTER_EN
    begin
      bit same;
      for (int i = FILT_LEN - 1; i > 0; i--) m_win[i] = m_win[i-1];
      m_win[0] = b;
      same = 1;
      for (int i = 1; i < FILT_LEN; i++) if (m_win[i] != b) same = 0;
      lnew = same ? b : m_lh[0];
    end
`else
    lnew = b;
`endif
    m_lh[3] = m_lh[2]; m_lh[2] = m_lh[1]; m_lh[1] = m_lh[0]; m_lh[0] = lnew;
    e_pv = 0;
    e_to = 0;
    if (m_lh[2] && !m_lh[3]) begin
      e_edge = (e_edge + 1) % 65536;
      if (!m_active) begin
        m_active = 1;
        m_nper   = 0;
        e_lock   = 0;
      end else begin
        p = m_k - m_last_rise;
        d = p - m_lastp;
        if (d < 0) d = -d;
        e_po   = p;
        e_pv   = 1;
        e_lock = (m_nper >= 1) && (d <= TOL);
        m_nper++;
        m_lastp = p;
      end
      m_last_rise = m_k;
    end else if (m_active && (m_k - m_last_rise) == TO_CYC) begin
      m_active = 0;
      e_to     = 1;
      e_lock   = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_step(blink_in);
      #1;
      chk("period_valid", period_valid, e_pv);
      chk("period_o", period_o, e_po);
      chk("locked", locked, e_lock);
      chk("timeout", timeout, e_to);
      chk("edge_cnt", edge_cnt, e_edge);
      if (timeout) to_seen++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      blink_in = 1'b1; cyc(hi);
      blink_in = 1'b0; cyc(lo);
    end
  endtask

  initial begin
    int t0, e0, base, per, hi, lo, glen;

    rst_n = 1'b0;
    blink_in = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    chk("rst_period_o", period_o, 0);
    chk("rst_locked", locked, 0);
    chk("rst_edge_cnt", edge_cnt, 0);

    // Quiet input: nothing may move.
    cyc(1000);
    chk("quiet_edge_cnt", edge_cnt, 0);
    chk("quiet_period_o", period_o, 0);

    // Steady P=100 square wave.
    wave(50, 50, 5);
    chk("p100_edges", edge_cnt, 5);
    chk("p100_period", period_o, 100);
    chk("p100_locked", locked, 1);

    // Input stuck high after lock.
    t0 = to_seen;
    blink_in = 1'b1;
    cyc(260);
    chk("stuck_timeouts", to_seen - t0, 1);
    chk("stuck_locked", locked, 0);
    blink_in = 1'b0;
    cyc(20);

    // Lock at 100, then step to 110.
    wave(50, 50, 4);
    wave(55, 55, 1);
    blink_in = 1'b1;
    cyc(8);
    chk("step_unlock", locked, 0);
    chk("step_period", period_o, 110);
    cyc(47);
    blink_in = 1'b0;
    cyc(55);
    blink_in = 1'b1;
    cyc(8);
    chk("step_relock", locked, 1);
    chk("step_period2", period_o, 110);
    cyc(47);
    blink_in = 1'b0;
    cyc(55);

    // Period equal to TIMEOUT_CYC: the rise wins.
    t0 = to_seen;
    wave(100, 100, 3);
    blink_in = 1'b1;
    cyc(8);
    chk("edge_to_period", period_o, TO_CYC);
    chk("edge_to_locked", locked, 1);
    chk("edge_to_nopulse", to_seen - t0, 0);
    cyc(92);
    blink_in = 1'b0;
    cyc(101);
    blink_in = 1'b1;
    cyc(8);
    chk("p201_timeout", to_seen - t0, 1);
    cyc(92);
    blink_in = 1'b0;
    cyc(210);

    // Short glitch inside a low phase.
    e0 = e_edge;
    blink_in = 1'b1;
    cyc(2);
    blink_in = 1'b0;
    cyc(20);
`ifdef BLINK_MONITOR_GLITCH_FILTER_EN
    chk("glitch_edges", edge_cnt, (e0) % 65536);
`else
    chk("glitch_edges", edge_cnt, (e0 + 1) % 65536);
`endif
    cyc(210);

    // Asynchronous reset while locked, input high across the release.
    wave(50, 50, 3);
    blink_in = 1'b1;
    cyc(8);
    chk("pre_rst_locked", locked, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_period_o", period_o, 0);
    chk("async_locked", locked, 0);
    chk("async_edge_cnt", edge_cnt, 0);
    chk("async_valid", period_valid, 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(8);
    chk("post_rst_edges", edge_cnt, 1);
    chk("post_rst_period", period_o, 0);
    chk("post_rst_locked", locked, 0);
    blink_in = 1'b0;
    cyc(50);

    // Randomized groups of jittered periods, with occasional gaps and glitches.
    for (int g = 0; g < 8; g++) begin
      base = $urandom_range(8, 150);
      for (int i = 0; i < 6; i++) begin
        per = base + $urandom_range(0, 8) - 4;
        hi  = per / 2;
        lo  = per - hi;
        if ($urandom_range(0, 7) == 0) lo += 180;
        blink_in = 1'b1;
        cyc(hi);
        blink_in = 1'b0;
        if (lo > 20 && $urandom_range(0, 5) == 0) begin
          glen = $urandom_range(1, 5);
          cyc(5);
          blink_in = 1'b1;
          cyc(glen);
          blink_in = 1'b0;
          cyc(lo - 5 - glen);
        end else begin
          cyc(lo);
        end
      end
    end
    cyc(250);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
